// File: rtl/alu_seq_if.sv
// alu_seq_if -- issue/result bundle between the execute stage and alu_seq.
//   master (execute stage): drives Start, A, B, ALUCtrl; observes results.
//   slave  (alu_seq)      : samples the request, drives Busy/Done/Rez/flags.
//   Start/A/B/ALUCtrl : request, sampled on an edge where Busy=0
//   Busy              : MOD iteration in progress
//   Done              : one-cycle completion pulse
//   Rez, COut, Overflow, Zero, DivByZero : registered result and flags
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUCtrl;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Rez;
  logic             COut;
  logic             Overflow;
  logic             Zero;
  logic             DivByZero;

  modport master (
    output Start, A, B, ALUCtrl,
    input  Busy, Done, Rez, COut, Overflow, Zero, DivByZero
  );

  modport slave (
    input  Start, A, B, ALUCtrl,
    output Busy, Done, Rez, COut, Overflow, Zero, DivByZero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- registered N-bit ALU with a multi-cycle unsigned MOD engine.
//   Clock   : rising-edge clock
//   Reset_n : asynchronous active-low reset
//   io      : alu_seq_if.slave (Start/A/B/ALUCtrl in; Busy/Done/Rez/flags out)
// Single-cycle ops (AND/OR/XOR/ADD/SUB/SLT/reserved, MOD by zero) complete
// on the accepting edge. MOD with a nonzero divisor runs a restoring
// division for WIDTH iterations and returns the remainder.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic     Clock,
  input  logic     Reset_n,
  alu_seq_if.slave io
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE, DIV} state_t;

  state_t           state;
  logic             busy, done, cout, ovf, zero, dbz;
  logic [WIDTH-1:0] rez;
  logic [WIDTH-1:0] dvd;   // dividend shift register
  logic [WIDTH-1:0] dvs;   // latched divisor
  logic [WIDTH-1:0] rem;   // partial remainder; always < divisor after an iteration
  logic [CW-1:0]    cnt;

  // ---------------- single-cycle datapath ----------------
  logic             inv;
  logic [WIDTH:0]   sum;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] res_c;
  logic             cout_c, ovf_c, dbz_c;
  logic             is_div;

  // SUB and SLT both evaluate A + ~B + 1.
  assign inv     = (io.ALUCtrl == OP_SUB) || (io.ALUCtrl == OP_SLT);
  assign sum     = {1'b0, io.A} + {1'b0, (io.B ^ {WIDTH{inv}})} + {{WIDTH{1'b0}}, inv};
  assign add_ovf = (io.A[WIDTH-1] == io.B[WIDTH-1]) && (sum[WIDTH-1] != io.A[WIDTH-1]);
  assign sub_ovf = (io.A[WIDTH-1] != io.B[WIDTH-1]) && (sum[WIDTH-1] != io.A[WIDTH-1]);
  assign is_div  = (io.ALUCtrl == OP_MOD) && (io.B != '0);

  always_comb begin
    res_c  = '0;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    dbz_c  = 1'b0;
    case (io.ALUCtrl)
      OP_AND: res_c = io.A & io.B;
      OP_OR:  res_c = io.A | io.B;
      OP_XOR: res_c = io.A ^ io.B;
      OP_ADD: begin
        res_c  = sum[WIDTH-1:0];
        cout_c = sum[WIDTH];
        ovf_c  = add_ovf;
      end
      OP_SUB: begin
        res_c  = sum[WIDTH-1:0];
        cout_c = sum[WIDTH];     // 1 = no borrow
        ovf_c  = sub_ovf;
      end
      // Signed less-than: true sign of A-B is its msb corrected by overflow.
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sub_ovf};
      // Only reached for B==0 here; a nonzero divisor takes the DIV path.
      OP_MOD: begin
        res_c = io.A;
        dbz_c = 1'b1;
      end
      default: res_c = '0;     // reserved encoding
    endcase
  end

  // ---------------- restoring division step ----------------
  logic [WIDTH:0]   rsh;
  logic             ge;
  logic [WIDTH:0]   rdiff;
  logic [WIDTH-1:0] rem_nxt;

  assign rsh     = {rem, dvd[WIDTH-1]};
  assign ge      = rsh >= {1'b0, dvs};
  assign rdiff   = rsh - {1'b0, dvs};
  // After the restore the remainder is below the divisor, so WIDTH bits hold it.
  assign rem_nxt = ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];

  // ---------------- control FSM and output registers ----------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      rez   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      dbz   <= 1'b0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (io.Start) begin
            if (is_div) begin
              dvd   <= io.A;
              dvs   <= io.B;
              rem   <= '0;
              cnt   <= CW'(WIDTH);
              busy  <= 1'b1;
              state <= DIV;
            end else begin
              rez  <= res_c;
              cout <= cout_c;
              ovf  <= ovf_c;
              zero <= (res_c == '0);
              dbz  <= dbz_c;
              done <= 1'b1;
            end
          end
        end
        DIV: begin
          dvd <= dvd << 1;
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
          // Last iteration: publish the remainder in the same edge.
          if (cnt == CW'(1)) begin
            rez   <= rem_nxt;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= (rem_nxt == '0);
            dbz   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.Busy      = busy;
  assign io.Done      = done;
  assign io.Rez       = rez;
  assign io.COut      = cout;
  assign io.Overflow  = ovf;
  assign io.Zero      = zero;
  assign io.DivByZero = dbz;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH=16).
module tb_alu_seq;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  int   nchk = 0;
  int   nfail = 0;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .io      (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.Start   = s;
    bus.ALUCtrl = op;
    bus.A       = a;
    bus.B       = b;
  endtask

  task automatic chk_flags(input string tag, input logic [15:0] rez, input logic c,
                           input logic v, input logic z, input logic d);
    chk({tag, ".Rez"},  bus.Rez, rez);
    chk({tag, ".COut"}, {15'd0, bus.COut}, {15'd0, c});
    chk({tag, ".Ovf"},  {15'd0, bus.Overflow}, {15'd0, v});
    chk({tag, ".Zero"}, {15'd0, bus.Zero}, {15'd0, z});
    chk({tag, ".DBZ"},  {15'd0, bus.DivByZero}, {15'd0, d});
  endtask

  initial begin
    drive(1'b0, 3'b000, 16'h0, 16'h0);

    // Reset state
    step(); step();
    chk("rst.Busy", {15'd0, bus.Busy}, 16'd0);
    chk("rst.Done", {15'd0, bus.Done}, 16'd0);
    chk_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    step();
    chk("idle.Done", {15'd0, bus.Done}, 16'd0);

    // AND / OR / XOR back-to-back
    drive(1'b1, 3'b000, 16'hF0F0, 16'hFF00);
    step();
    chk("and.Rez", bus.Rez, 16'hF000);
    chk("and.Done", {15'd0, bus.Done}, 16'd1);
    drive(1'b1, 3'b010, 16'hF0F0, 16'hFF00);
    step();
    chk("or.Rez", bus.Rez, 16'hFFF0);
    chk("or.Done", {15'd0, bus.Done}, 16'd1);
    drive(1'b1, 3'b011, 16'hF0F0, 16'hFF00);
    step();
    chk("xor.Rez", bus.Rez, 16'h0FF0);
    chk("xor.Done", {15'd0, bus.Done}, 16'd1);
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    step();
    chk("xor.hold", bus.Rez, 16'h0FF0);
    chk("xor.Done0", {15'd0, bus.Done}, 16'd0);

    // ADD signed overflow
    drive(1'b1, 3'b001, 16'h7FFF, 16'h0001);
    step();
    chk_flags("add", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("add.Done", {15'd0, bus.Done}, 16'd1);

    // ADD with carry out: 0xFFFF + 0x0001 = 0x0000, carry 1, no overflow
    drive(1'b1, 3'b001, 16'hFFFF, 16'h0001);
    step();
    chk_flags("addc", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // SUB equal operands
    drive(1'b1, 3'b110, 16'h0005, 16'h0005);
    step();
    chk_flags("sub", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // SUB with signed overflow: 0x8000 - 0x0001 = 0x7FFF, no borrow
    drive(1'b1, 3'b110, 16'h8000, 16'h0001);
    step();
    chk_flags("subv", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // SLT -1 < 1
    drive(1'b1, 3'b111, 16'hFFFF, 16'h0001);
    step();
    chk_flags("slt", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);

    // SLT with overflow: 0x7FFF < 0x8000 is false
    drive(1'b1, 3'b111, 16'h7FFF, 16'h8000);
    step();
    chk_flags("sltv", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reserved encoding
    drive(1'b1, 3'b101, 16'h1234, 16'h5678);
    step();
    chk_flags("rsv", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rsv.Done", {15'd0, bus.Done}, 16'd1);

    // Remainder of 1000 by 7, accepted on edge k
    drive(1'b1, 3'b100, 16'd1000, 16'd7);
    step();
    chk("mod.k.Busy", {15'd0, bus.Busy}, 16'd1);
    chk("mod.k.Done", {15'd0, bus.Done}, 16'd0);
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 3) drive(1'b1, 3'b001, 16'h0005, 16'h0003);  // ignored while busy
      else        drive(1'b0, 3'b100, 16'hABCD, 16'h0000);
      step();
      chk("mod.Busy", {15'd0, bus.Busy}, 16'd1);
      chk("mod.Done", {15'd0, bus.Done}, 16'd0);
    end
    step();  // edge k+16
    chk("mod.end.Busy", {15'd0, bus.Busy}, 16'd0);
    chk("mod.end.Done", {15'd0, bus.Done}, 16'd1);
    chk_flags("mod", 16'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("mod.Done0", {15'd0, bus.Done}, 16'd0);

    // Divide by zero, latency 1, then a remainder op issued straight behind it
    drive(1'b1, 3'b100, 16'h1234, 16'h0000);
    step();
    chk("mz.Done", {15'd0, bus.Done}, 16'd1);
    chk("mz.Busy", {15'd0, bus.Busy}, 16'd0);
    chk_flags("mz", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3'b100, 16'hFFFF, 16'h0100);
    step();
    chk("m2.k.Busy", {15'd0, bus.Busy}, 16'd1);
    chk("m2.k.Done", {15'd0, bus.Done}, 16'd0);
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    for (int i = 1; i <= 15; i++) step();
    chk("m2.pre.Busy", {15'd0, bus.Busy}, 16'd1);
    // Issue the next MOD during the cycle in which this one reports Done
    drive(1'b1, 3'b100, 16'd1000, 16'd7);
    step();
    chk("m2.Done", {15'd0, bus.Done}, 16'd1);
    chk_flags("m2", 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step();  // edge k: the new MOD is accepted
    chk("m3.k.Busy", {15'd0, bus.Busy}, 16'd1);
    chk("m3.k.Done", {15'd0, bus.Done}, 16'd0);
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    for (int i = 1; i <= 5; i++) step();  // through edge k+5
    Reset_n = 1'b0;
    #1;
    chk("rmid.Busy", {15'd0, bus.Busy}, 16'd0);
    chk("rmid.Done", {15'd0, bus.Done}, 16'd0);
    chk_flags("rmid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    Reset_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 24; i++) begin
        step();
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) seen++;
      end
      chk("rmid.quiet", 16'(seen), 16'd0);
    end
    chk("rmid.Rez", bus.Rez, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
